// File: rtl/compass_edge_sched_pkg.sv
// Shared types, Robinson compass kernel table and the output clamp for the edge scheduler.
package compass_pkg;

    localparam int NUM_KERNELS = 8;
    localparam int NUM_TAPS    = 9;
    localparam int COEF_W      = 3;

    typedef enum logic [2:0] {
        DIR_E  = 3'd0,
        DIR_NE = 3'd1,
        DIR_N  = 3'd2,
        DIR_NW = 3'd3,
        DIR_W  = 3'd4,
        DIR_SW = 3'd5,
        DIR_S  = 3'd6,
        DIR_SE = 3'd7
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Row-major taps, index 3*row+col; kernels 4..7 are the negations of 0..3.
    localparam logic signed [COEF_W-1:0] KERNEL_COEF [NUM_KERNELS][NUM_TAPS] = '{
        '{-3'sd1,  3'sd0,  3'sd1, -3'sd2,  3'sd0,  3'sd2, -3'sd1,  3'sd0,  3'sd1},
        '{ 3'sd0,  3'sd1,  3'sd2, -3'sd1,  3'sd0,  3'sd1, -3'sd2, -3'sd1,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1,  3'sd0,  3'sd0,  3'sd0, -3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd2,  3'sd1,  3'sd0,  3'sd1,  3'sd0, -3'sd1,  3'sd0, -3'sd1, -3'sd2},
        '{ 3'sd1,  3'sd0, -3'sd1,  3'sd2,  3'sd0, -3'sd2,  3'sd1,  3'sd0, -3'sd1},
        '{ 3'sd0, -3'sd1, -3'sd2,  3'sd1,  3'sd0, -3'sd1,  3'sd2,  3'sd1,  3'sd0},
        '{-3'sd1, -3'sd2, -3'sd1,  3'sd0,  3'sd0,  3'sd0,  3'sd1,  3'sd2,  3'sd1},
        '{-3'sd2, -3'sd1,  3'sd0, -3'sd1,  3'sd0,  3'sd1,  3'sd0,  3'sd1,  3'sd2}
    };

    function automatic logic [NUM_TAPS*COEF_W-1:0] kernel_taps(input logic [2:0] k);
        logic [NUM_TAPS*COEF_W-1:0] taps;
        taps = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            taps[COEF_W*t +: COEF_W] = KERNEL_COEF[k][t];
        end
        return taps;
    endfunction

    function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v < 0) begin
            r = 8'd0;
        end else if (v > 32'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/compass_edge_sched_dot9.sv
// Combinational 9-tap signed dot product of one pixel window against one 3-bit kernel.
module compass_dot9
    import compass_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int ACC_W = 16
) (
    input  logic [9*PIX_W-1:0]           win_i,
    input  logic [NUM_TAPS*COEF_W-1:0]   coef_i,
    output logic signed [ACC_W-1:0]      sum_o
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] coef_ext;

    always_comb begin
        acc      = '0;
        pix_ext  = '0;
        coef_ext = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            pix_ext  = ACC_W'($signed(win_i[PIX_W*t +: PIX_W]));
            coef_ext = ACC_W'($signed(coef_i[COEF_W*t +: COEF_W]));
            acc      = acc + pix_ext * coef_ext;
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/compass_edge_sched.sv
// Sequences the eight Robinson kernels through one shared dot-product engine and keeps the
// best signed response; interior windows take 8 RUN cycles, border windows bypass straight to DONE.
module compass_edge_sched
    import compass_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*PIX_W-1:0]   in_win,
    input  logic                 in_border,
    input  logic [7:0]           in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_mag,
    output logic [2:0]           out_dir,
    output logic                 busy
);

    state_e                  state_q;
    logic [2:0]              kidx_q;
    logic [9*PIX_W-1:0]      win_q;
    logic [7:0]              mask_q;
    logic signed [ACC_W-1:0] best_q;
    logic signed [ACC_W-1:0] best_d;
    logic                    best_set_q;
    logic                    best_set_d;
    dir_e                    dir_q;
    dir_e                    dir_d;
    logic                    out_valid_q;
    logic [7:0]              out_mag_q;
    logic [2:0]              out_dir_q;
    logic signed [ACC_W-1:0] sum;
    logic [7:0]              final_mag;
    logic [2:0]              final_dir;

    compass_dot9 #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_dot9 (
        .win_i  (win_q),
        .coef_i (kernel_taps(kidx_q)),
        .sum_o  (sum)
    );

    // Strict greater-than keeps the lower kernel index on ties.
    always_comb begin
        best_d     = best_q;
        best_set_d = best_set_q;
        dir_d      = dir_q;
        if (mask_q[kidx_q] && (!best_set_q || (sum > best_q))) begin
            best_d     = sum;
            best_set_d = 1'b1;
            dir_d      = dir_e'(kidx_q);
        end
    end

    // An empty mask never sets best, which reports as magnitude 0, direction E.
    always_comb begin
        final_mag = 8'd0;
        final_dir = 3'd0;
        if (best_set_d) begin
            final_mag = clamp_u8(32'(best_d));
            final_dir = dir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kidx_q      <= 3'd0;
            win_q       <= '0;
            mask_q      <= 8'd0;
            best_q      <= '0;
            best_set_q  <= 1'b0;
            dir_q       <= DIR_E;
            out_valid_q <= 1'b0;
            out_mag_q   <= 8'd0;
            out_dir_q   <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        win_q  <= in_win;
                        mask_q <= in_mask;
                        if (in_border) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_mag_q   <= 8'd0;
                            out_dir_q   <= 3'd0;
                        end else begin
                            state_q    <= ST_RUN;
                            kidx_q     <= 3'd0;
                            best_q     <= '0;
                            best_set_q <= 1'b0;
                            dir_q      <= DIR_E;
                        end
                    end
                end
                ST_RUN: begin
                    best_q     <= best_d;
                    best_set_q <= best_set_d;
                    dir_q      <= dir_d;
                    if (kidx_q == 3'd7) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_mag_q   <= final_mag;
                        out_dir_q   <= final_dir;
                    end else begin
                        kidx_q <= kidx_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held, even if the state is already IDLE.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_dir   = out_dir_q;

endmodule

// File: tb/tb_compass_edge_sched.sv
// Self-checking bench for compass_edge_sched: directed vector table, multi-cycle corner sequences,
// and randomized windows checked against a kernel-arithmetic reference model.
module tb_compass_edge_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_win;
    logic        in_border;
    logic [7:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_mag;
    logic [2:0]  out_dir;
    logic        busy;

    int n_cmp;
    int n_bad;

    compass_edge_sched #(.PIX_W(8), .ACC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .in_border (in_border),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_dir   (out_dir),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Four base kernels; directions 4..7 are their negations.
    int kbase [4][9] = '{
        '{-1, 0, 1, -2, 0, 2, -1, 0, 1},
        '{ 0, 1, 2, -1, 0, 1, -2, -1, 0},
        '{ 1, 2, 1,  0, 0, 0, -1, -2, -1},
        '{ 2, 1, 0,  1, 0, -1, 0, -1, -2}
    };

    typedef struct {
        string       name;
        logic [71:0] win;
        logic        border;
        logic [7:0]  mask;
        int          exp_mag;
        int          exp_dir;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] make_cols(input int a, input int b, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            w[8*(3*r+0) +: 8] = 8'(a);
            w[8*(3*r+1) +: 8] = 8'(b);
            w[8*(3*r+2) +: 8] = 8'(c);
        end
        return w;
    endfunction

    function automatic void model(input logic [71:0] w, input logic b, input logic [7:0] m,
                                  output int mag, output int dir);
        int best;
        int s;
        int coef;
        bit have;
        mag  = 0;
        dir  = 0;
        best = 0;
        have = 0;
        if (!b) begin
            for (int k = 0; k < 8; k++) begin
                if (m[k]) begin
                    s = 0;
                    for (int t = 0; t < 9; t++) begin
                        coef = (k < 4) ? kbase[k][t] : -kbase[k-4][t];
                        s += int'($signed(w[8*t +: 8])) * coef;
                    end
                    if (!have || s > best) begin
                        best = s;
                        dir  = k;
                        have = 1;
                    end
                end
            end
            if (have) mag = (best < 0) ? 0 : ((best > 255) ? 255 : best);
        end
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic send(input logic [71:0] w, input logic b, input logic [7:0] m,
                        output int mag, output int dir, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", 0, 1);
        in_win    = w;
        in_border = b;
        in_mask   = m;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_win    = {$urandom, $urandom, 8'($urandom)};
        in_mask   = 8'($urandom);
        in_border = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        mag = int'(out_mag);
        dir = int'(out_dir);
    endtask

    initial begin
        int mag;
        int dir;
        int lat;
        int emag;
        int edir;
        int hold;
        logic [71:0] w;
        logic [7:0]  m;
        logic        b;

        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_win    = '0;
        in_border = 1'b0;
        in_mask   = 8'd0;
        out_ready = 1'b1;

        vecs[0] = '{"uniform10",   make_cols(10, 10, 10), 1'b0, 8'hFF, 0,   0, 9};
        vecs[1] = '{"east80",      make_cols(0, 0, 20),   1'b0, 8'hFF, 80,  0, 9};
        vecs[2] = '{"west80",      make_cols(20, 0, 0),   1'b0, 8'hFF, 80,  4, 9};
        vecs[3] = '{"tie_ne_se",   make_cols(0, 0, 20),   1'b0, 8'hFE, 60,  1, 9};
        vecs[4] = '{"empty_mask",  make_cols(0, 0, 20),   1'b0, 8'h00, 0,   0, 9};
        vecs[5] = '{"clamp_hi",    make_cols(0, 0, 100),  1'b0, 8'hFF, 255, 0, 9};
        vecs[6] = '{"border",      make_cols(0, 0, 100),  1'b1, 8'hFF, 0,   0, 1};
        vecs[7] = '{"clamp_neg",   make_cols(0, 0, -20),  1'b0, 8'h01, 0,   0, 9};

        repeat (3) @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_out_mag",   int'(out_mag),   0);
        check("rst_out_dir",   int'(out_dir),   0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].win, vecs[i].border, vecs[i].mask, mag, dir, lat);
            check({vecs[i].name, "_mag"}, mag, vecs[i].exp_mag);
            check({vecs[i].name, "_dir"}, dir, vecs[i].exp_dir);
            check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_excl"}, int'(in_ready), 0);
            @(negedge clk);
        end

        // Backpressure: result must hold while out_ready is low and in_valid is pending.
        out_ready = 1'b0;
        send(make_cols(0, 0, 20), 1'b0, 8'hFF, mag, dir, lat);
        check("bp_lat", lat, 9);
        in_win    = make_cols(20, 0, 0);
        in_mask   = 8'hFF;
        in_border = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_mag",   int'(out_mag),   80);
            check("bp_dir",   int'(out_dir),   0);
            check("bp_ready", int'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_busy",  int'(busy),      0);
        check("bp_release_ready", int'(in_ready),  1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", int'(busy), 1);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_lat", lat, 9);
        check("bp_second_mag", int'(out_mag), 80);
        check("bp_second_dir", int'(out_dir), 4);
        @(negedge clk);

        // Reset pulse while kernel 4 is being evaluated.
        in_win    = make_cols(0, 0, 100);
        in_mask   = 8'hFF;
        in_border = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy",      int'(busy),      0);
        rst_n = 1'b1;
        @(negedge clk);
        send(make_cols(0, 0, 20), 1'b0, 8'hFE, mag, dir, lat);
        check("abort_fresh_mag", mag, 60);
        check("abort_fresh_dir", dir, 1);
        check("abort_fresh_lat", lat, 9);
        @(negedge clk);

        // Randomized windows with occasional output stalls.
        for (int i = 0; i < 60; i++) begin
            w = '0;
            for (int t = 0; t < 9; t++) w[8*t +: 8] = 8'($urandom);
            m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 7) == 0);
            model(w, b, m, emag, edir);
            send(w, b, m, mag, dir, lat);
            check("rand_mag", mag, emag);
            check("rand_dir", dir, edir);
            check("rand_lat", lat, b ? 1 : 9);
            if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                hold = $urandom_range(1, 4);
                for (int c = 0; c < hold; c++) begin
                    @(negedge clk);
                    check("rand_hold_mag", int'(out_mag), emag);
                    check("rand_hold_valid", int'(out_valid), 1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
